// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: oversamples CS/SCLK/DATA with clk, rebuilds
// DATA_W-bit words and offers them on a valid/ready port with a single
// holding register. Reports partial frames and dropped words as pulses.
module spi_rx_deser #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_cs_1,
  input  logic                          spi_sclk,
  input  logic                          spi_data,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(DATA_W):0]       bit_count
);

  localparam int unsigned CNT_W     = $clog2(DATA_W) + 1;
  localparam int unsigned SYNC_LAST = SYNC_STAGES - 1;
  // Synchronizer bit order is {cs, sclk, data}; idle is CS deasserted, SCLK low.
  localparam logic [2:0]  SYNC_IDLE = 3'b100;

  logic [2:0]        sync_q [SYNC_STAGES];
  logic              cs_s, sclk_s, data_s;
  logic              cs_p_q, sclk_p_q, data_p_q;
  logic              rise, cs_rise, cs_fall;

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              word_done;
  logic [DATA_W-1:0] word;

  // Input synchronizer chain for all three SPI lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      sync_q[0] <= {spi_cs_1, spi_sclk, spi_data};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cs_s   = sync_q[SYNC_LAST][2];
  assign sclk_s = sync_q[SYNC_LAST][1];
  assign data_s = sync_q[SYNC_LAST][0];

  // One-cycle history of the synchronized lines for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_p_q   <= 1'b1;
      sclk_p_q <= 1'b0;
      data_p_q <= 1'b0;
    end else begin
      cs_p_q   <= cs_s;
      sclk_p_q <= sclk_s;
      data_p_q <= data_s;
    end
  end

  // Master moves DATA on the SCLK rising edge, so the bit is the pre-edge sample.
  assign rise    = sclk_s & ~sclk_p_q & ~cs_s;
  assign cs_rise = cs_s & ~cs_p_q;
  assign cs_fall = ~cs_s & cs_p_q;

  // Shift/count next state, frame boundaries and holding-register update.
  always_comb begin
    sr_d        = sr_q;
    bit_count_d = bit_count_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    word        = sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;

    if (cs_rise) begin
      frame_err_d = (bit_count_q != '0);
      sr_d        = '0;
      bit_count_d = '0;
    end else begin
      if (cs_fall) begin
        sr_d        = '0;
        bit_count_d = '0;
      end
      if (rise) begin
        if (MSB_FIRST != 0) word = {sr_d[DATA_W-2:0], data_p_q};
        else                word = {data_p_q, sr_d[DATA_W-1:1]};
        sr_d = word;
        if (bit_count_d == CNT_W'(DATA_W - 1)) begin
          word_done   = 1'b1;
          bit_count_d = '0;
        end else begin
          bit_count_d = bit_count_d + CNT_W'(1);
        end
      end
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q        <= '0;
      bit_count_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_count_q <= bit_count_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Testbench for spi_rx_deser: an MSB-first and an LSB-first instance share
// one SPI bus; a bit-level reference model predicts words and pulses.
module tb_spi_rx_deser;

  logic        clk = 1'b0;
  logic        reset, spi_cs_1, spi_sclk, spi_data, rx_ready;
  logic [15:0] rx_data0, rx_data1;
  logic        rx_valid0, rx_valid1, frame_err0, frame_err1, overrun0, overrun1;
  logic [4:0]  bit_count0, bit_count1;

  spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(2), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .spi_cs_1(spi_cs_1), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready), .frame_err(frame_err0), .overrun(overrun0),
    .bit_count(bit_count0));

  spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(2), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .spi_cs_1(spi_cs_1), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready), .frame_err(frame_err1), .overrun(overrun1),
    .bit_count(bit_count1));

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] msb; logic [15:0] lsb; } exp_t;
  exp_t        exp_q[$];
  exp_t        e_pop;
  int          n_cmp = 0, n_err = 0;
  int          exp_ovr = 0, exp_ferr = 0;
  int          act_ovr0 = 0, act_ovr1 = 0, act_ferr0 = 0, act_ferr1 = 0;
  bit          model_full = 1'b0;
  int          cnt = 0;
  logic        bits_a [16];
  bit          lat_chk = 1'b0, ready_hook = 1'b0;
  logic [15:0] last_data1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Word value from the 16 received bits in arrival order.
  task automatic complete_word();
    logic [15:0] m, l;
    exp_t t;
    m = '0; l = '0;
    for (int i = 0; i < 16; i++) begin
      if (bits_a[i]) begin
        m = m | (16'(1) << (15 - i));
        l = l | (16'(1) << i);
      end
    end
    if (rx_ready || !model_full) begin
      t.msb = m; t.lsb = l;
      exp_q.push_back(t);
      model_full = !rx_ready;
    end else begin
      exp_ovr++;
    end
  endtask

  // One SCLK period; DATA flips to ~b on the same clk edge SCLK rises.
  task automatic send_bit(input logic b);
    int lo, hi;
    lo = $urandom_range(2, 4);
    hi = $urandom_range(3, 5);
    spi_sclk = 1'b0; spi_data = b;
    tick(lo);
    spi_sclk = 1'b1; spi_data = ~b;
    for (int h = 1; h <= hi; h++) begin
      tick(1);
      if (h == 2 && lat_chk && cnt == 15) chk("latency_pre", 32'(rx_valid0), 32'd0);
      if (h == 2 && ready_hook && cnt == 15) rx_ready = 1'b1;
      if (h == 3) begin
        bits_a[cnt] = b;
        cnt = cnt + 1;
        if (cnt == 16) begin cnt = 0; complete_word(); end
        chk("bit_count_msb", 32'(bit_count0), 32'(cnt));
        chk("bit_count_lsb", 32'(bit_count1), 32'(cnt));
        if (lat_chk && cnt == 0) chk("latency_valid", 32'(rx_valid0), 32'd1);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[15-i]);
  endtask

  // Close the CS window, optionally wiggle SCLK while deselected, reopen.
  task automatic end_frame(input int gap, input bit noise);
    spi_sclk = 1'b0;
    tick(2);
    spi_cs_1 = 1'b1;
    if (cnt != 0) exp_ferr++;
    cnt = 0;
    if (noise) begin
      tick(3);
      repeat (3) begin
        spi_sclk = 1'b1; spi_data = 1'($urandom);
        tick(2);
        spi_sclk = 1'b0;
        tick(2);
      end
    end
    tick(gap);
    spi_cs_1 = 1'b0;
    tick(4);
  endtask

  task automatic check_pulses();
    chk("overrun_msb", 32'(act_ovr0), 32'(exp_ovr));
    chk("overrun_lsb", 32'(act_ovr1), 32'(exp_ovr));
    chk("frame_err_msb", 32'(act_ferr0), 32'(exp_ferr));
    chk("frame_err_lsb", 32'(act_ferr1), 32'(exp_ferr));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data_msb"}, 32'(rx_data0), 32'd0);
    chk({tag, "_rx_valid_msb"}, 32'(rx_valid0), 32'd0);
    chk({tag, "_frame_err_msb"}, 32'(frame_err0), 32'd0);
    chk({tag, "_overrun_msb"}, 32'(overrun0), 32'd0);
    chk({tag, "_bit_count_msb"}, 32'(bit_count0), 32'd0);
    chk({tag, "_rx_data_lsb"}, 32'(rx_data1), 32'd0);
    chk({tag, "_rx_valid_lsb"}, 32'(rx_valid1), 32'd0);
    chk({tag, "_bit_count_lsb"}, 32'(bit_count1), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted word, counts pulse cycles.
  always @(negedge clk) begin
    if (reset) begin
      if (overrun0)   act_ovr0++;
      if (overrun1)   act_ovr1++;
      if (frame_err0) act_ferr0++;
      if (frame_err1) act_ferr1++;
      if (rx_valid0 && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %h expected no word (t=%0t)", rx_data0, $time);
        end else begin
          e_pop = exp_q.pop_front();
          chk("rx_data_msb", 32'(rx_data0), 32'(e_pop.msb));
          chk("rx_data_lsb", 32'(rx_data1), 32'(e_pop.lsb));
          chk("rx_valid_lsb", 32'(rx_valid1), 32'd1);
          last_data1 = rx_data1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stream6 [16];
    logic ab3 [7];
    int   kind, n, k;
    logic [15:0] w;
    stream6 = '{1,0,0,1,0,1,1,0,1,0,1,0,0,1,0,1};
    ab3     = '{1,0,1,1,0,1,0};

    reset = 1'b0; spi_cs_1 = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0; rx_ready = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(3);
    spi_cs_1 = 1'b0;
    tick(4);

    // Single word, consumer ready, with latency check on the last bit.
    rx_ready = 1'b1; model_full = 1'b0;
    lat_chk = 1'b1;
    send_word(16'hA569, 16);
    lat_chk = 1'b0;
    end_frame(3, 1'b0);
    check_pulses();

    // Back-to-back words with consumer stalled: second one overruns.
    rx_ready = 1'b0;
    send_word(16'h2563, 16);
    end_frame(2, 1'b0);
    send_word(16'h9B63, 16);
    end_frame(1, 1'b0);
    check_pulses();
    chk("held_valid", 32'(rx_valid0), 32'd1);
    chk("held_data", 32'(rx_data0), 32'h2563);
    rx_ready = 1'b1; model_full = 1'b0;
    tick(1);
    rx_ready = 1'b0;
    chk("valid_after_take", 32'(rx_valid0), 32'd0);

    // Aborted 7-bit frame, then a good frame.
    rx_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(ab3[i]);
    end_frame(3, 1'b1);
    check_pulses();
    chk("valid_after_abort", 32'(rx_valid0), 32'd0);
    send_word(16'h6A61, 16);
    end_frame(2, 1'b0);

    // Completion coinciding with the transfer of the previous word.
    rx_ready = 1'b0;
    send_word(16'hA265, 16);
    end_frame(2, 1'b0);
    ready_hook = 1'b1;
    send_word(16'h7564, 16);
    ready_hook = 1'b0;
    end_frame(2, 1'b0);
    check_pulses();

    // Asynchronous reset mid-frame with a buffered word.
    rx_ready = 1'b0;
    send_word(16'h2563, 16);
    end_frame(2, 1'b0);
    send_word(16'hA569, 9);
    spi_sclk = 1'b0;
    tick(2);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete(); model_full = 1'b0; cnt = 0;
    tick(3);
    reset = 1'b1;
    tick(4);
    rx_ready = 1'b1;
    send_word(16'h9B63, 16);
    end_frame(2, 1'b0);
    check_pulses();

    // Serial stream that reads A569 when assembled LSB first.
    for (int i = 0; i < 16; i++) send_bit(stream6[i]);
    end_frame(2, 1'b0);
    chk("lsb_first_word", 32'(last_data1), 32'hA569);

    // Randomized frames: aborts, extra bits, stalls, short gaps, noise.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) rx_ready = 1'b0;
      else begin rx_ready = 1'b1; model_full = 1'b0; end
      w    = 16'($urandom);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        n = $urandom_range(1, 15);
        send_word(w, n);
      end else if (kind == 1) begin
        send_word(w, 16);
        k = $urandom_range(0, 15);
        for (int i = 0; i < k; i++) send_bit(1'($urandom));
      end else begin
        send_word(w, 16);
      end
      end_frame($urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    rx_ready = 1'b1; model_full = 1'b0;
    tick(10);
    check_pulses();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
